// File: rtl/player_jump_sprite.sv
// Player vertical jump physics (GROUND/RISE/FALL, once per frame) plus registered sprite hit test.
// Optional one-shot mid-air jump is enabled by defining DOUBLE_JUMP_EN.
module player_jump_sprite #(
  parameter int PlayerHeight = 60,
  parameter int PlayerWidth  = 40,
  parameter int PlayerOffset = 0,
  parameter int ScreenHeight = 480,
  parameter int JumpVel      = 12,
  parameter int Gravity      = 1,
  parameter int MaxFallVel   = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_tick_i,
  input  logic       jump_i,
  input  logic       player_en_i,
  input  logic [9:0] x_i,
  input  logic [8:0] y_i,
  output logic [8:0] luc_loc_o,
  output logic       airborne_o,
  output logic       region_o
);

  typedef enum logic [1:0] {
    GROUND,
    RISE,
    FALL
  } state_e;

  localparam logic [8:0] GroundY    = 9'(ScreenHeight - PlayerHeight);
  localparam logic [5:0] JumpV      = 6'(JumpVel);
  localparam logic [5:0] GravV      = 6'(Gravity);
  localparam logic [5:0] MaxFallV   = 6'(MaxFallVel);
  localparam logic [10:0] OffsetX   = 11'(PlayerOffset);
  localparam logic [10:0] WidthX    = 11'(PlayerWidth);
  localparam logic [9:0]  HeightY   = 10'(PlayerHeight);

  state_e     state_q, state_d;
  logic [8:0] y_q, y_d;
  logic [5:0] vel_q, vel_d;
  logic       jump_req_q, jump_req_d;
  logic       jump_prev_q;
  logic       airborne_q;
  logic       region_q, region_d;

  logic       jump_req_eff;
  logic       air_jump;
  logic [6:0] vel_up;
  logic [5:0] vel_n;
  logic [9:0] fall_sum;
  logic [10:0] x_rel;
  logic [9:0]  y_rel;

`ifdef DOUBLE_JUMP_EN
  logic air_used_q, air_used_d;
`endif

  // An edge arriving on the tick cycle itself must still be honoured on that tick.
  assign jump_req_eff = jump_req_q | (jump_i & ~jump_prev_q);
  assign jump_req_d   = frame_tick_i ? 1'b0 : jump_req_eff;

`ifdef DOUBLE_JUMP_EN
  assign air_jump = jump_req_eff & ~air_used_q & (state_q != GROUND);
`else
  assign air_jump = 1'b0;
`endif

  assign vel_up   = {1'b0, vel_q} + {1'b0, GravV};
  assign vel_n    = (vel_up > {1'b0, MaxFallV}) ? MaxFallV : vel_up[5:0];
  assign fall_sum = {1'b0, y_q} + {4'b0, vel_n};

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
`ifdef DOUBLE_JUMP_EN
    air_used_d = air_used_q;
`endif
    if (frame_tick_i) begin
      if (air_jump) begin
        state_d = RISE;
        vel_d   = JumpV;
`ifdef DOUBLE_JUMP_EN
        air_used_d = 1'b1;
`endif
      end else begin
        unique case (state_q)
          GROUND: begin
            if (jump_req_eff) begin
              state_d = RISE;
              vel_d   = JumpV;
            end
          end
          RISE: begin
            if ({3'b0, vel_q} > y_q) begin
              y_d     = '0;
              vel_d   = '0;
              state_d = FALL;
            end else begin
              y_d = y_q - {3'b0, vel_q};
              if (vel_q <= GravV) begin
                vel_d   = '0;
                state_d = FALL;
              end else begin
                vel_d = vel_q - GravV;
              end
            end
          end
          FALL: begin
            if (fall_sum >= {1'b0, GroundY}) begin
              y_d     = GroundY;
              vel_d   = '0;
              state_d = GROUND;
`ifdef DOUBLE_JUMP_EN
              air_used_d = 1'b0;
`endif
            end else begin
              y_d   = fall_sum[8:0];
              vel_d = vel_n;
            end
          end
          default: begin
            state_d = GROUND;
            y_d     = GroundY;
            vel_d   = '0;
          end
        endcase
      end
    end
  end

  // Wrapping subtraction folds the lower and upper bound into one unsigned compare.
  assign x_rel    = {1'b0, x_i} - OffsetX;
  assign y_rel    = {1'b0, y_i} - {1'b0, y_q};
  assign region_d = player_en_i & (x_rel < WidthX) & (y_rel < HeightY);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= GROUND;
      y_q         <= GroundY;
      vel_q       <= '0;
      jump_req_q  <= 1'b0;
      jump_prev_q <= 1'b0;
      airborne_q  <= 1'b0;
      region_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      vel_q       <= vel_d;
      jump_req_q  <= jump_req_d;
      jump_prev_q <= jump_i;
      airborne_q  <= (state_d != GROUND);
      region_q    <= region_d;
    end
  end

`ifdef DOUBLE_JUMP_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) air_used_q <= 1'b0;
    else       air_used_q <= air_used_d;
  end
`endif

  assign luc_loc_o  = y_q;
  assign airborne_o = airborne_q;
  assign region_o   = region_q;

endmodule

// File: tb/tb_player_jump_sprite.sv
// Directed bench for player_jump_sprite: reset, jump trajectory, hit test, ceiling clamp,
// jump-edge corner cases and the optional air jump (expectations follow DOUBLE_JUMP_EN).
module tb_player_jump_sprite;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       frame_tick_i = 1'b0;
  logic       jump_i = 1'b0;
  logic       jump2_i = 1'b0;
  logic       player_en_i = 1'b0;
  logic [9:0] x_i = '0;
  logic [8:0] y_i = '0;

  logic [8:0] luc_loc_o, luc2_o;
  logic       airborne_o, air2_o;
  logic       region_o, region2_o;

  int n_checks = 0;
  int n_fail   = 0;

  player_jump_sprite dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .frame_tick_i(frame_tick_i),
    .jump_i      (jump_i),
    .player_en_i (player_en_i),
    .x_i         (x_i),
    .y_i         (y_i),
    .luc_loc_o   (luc_loc_o),
    .airborne_o  (airborne_o),
    .region_o    (region_o)
  );

  player_jump_sprite #(.JumpVel(63)) dut_ceil (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .frame_tick_i(frame_tick_i),
    .jump_i      (jump2_i),
    .player_en_i (player_en_i),
    .x_i         (x_i),
    .y_i         (y_i),
    .luc_loc_o   (luc2_o),
    .airborne_o  (air2_o),
    .region_o    (region2_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // All stimulus is applied 1 ns after a rising edge; outputs are sampled there too.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic tick();
    frame_tick_i = 1'b1;
    cyc(1);
    frame_tick_i = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick();
      cyc(1);
    end
  endtask

  task automatic press();
    jump_i = 1'b1;
    cyc(1);
    jump_i = 1'b0;
    cyc(1);
  endtask

  task automatic land(input string tag);
    int n;
    n = 0;
    while (airborne_o && n < 80) begin
      ticks(1);
      n++;
    end
    check({tag, "_air"}, 32'(airborne_o), 32'd0);
    check({tag, "_luc"}, 32'(luc_loc_o), 32'd420);
  endtask

  initial begin
    // Reset state
    cyc(3);
    rst_i = 1'b0;
    cyc(1);
    check("rst_luc", 32'(luc_loc_o), 32'd420);
    check("rst_air", 32'(airborne_o), 32'd0);
    check("rst_region", 32'(region_o), 32'd0);
    check("rst_luc2", 32'(luc2_o), 32'd420);

    // Asynchronous reset mid-jump, sampled before any further clock edge
    press();
    tick();
    check("mj_t0_air", 32'(airborne_o), 32'd1);
    tick();
    check("mj_t1_luc", 32'(luc_loc_o), 32'd408);
    player_en_i = 1'b1;
    x_i = 10'd10;
    y_i = 9'd410;
    cyc(1);
    check("mj_region", 32'(region_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("arst_luc", 32'(luc_loc_o), 32'd420);
    check("arst_air", 32'(airborne_o), 32'd0);
    check("arst_region", 32'(region_o), 32'd0);
    cyc(1);
    rst_i = 1'b0;
    player_en_i = 1'b0;
    cyc(1);

    // Single jump trajectory, tick 0 is the tick that takes the request
    press();
    tick();
    check("j_t0_luc", 32'(luc_loc_o), 32'd420);
    check("j_t0_air", 32'(airborne_o), 32'd1);
    player_en_i = 1'b1;
    x_i = 10'd5;
    y_i = 9'd470;
    tick();
    check("j_t1_luc", 32'(luc_loc_o), 32'd408);
    check("j_t1_region_old_y", 32'(region_o), 32'd1);
    cyc(1);
    check("j_t1_region_new_y", 32'(region_o), 32'd0);
    player_en_i = 1'b0;
    ticks(10);
    tick();
    check("j_t12_luc", 32'(luc_loc_o), 32'd342);
    check("j_t12_air", 32'(airborne_o), 32'd1);
    cyc(5);
    check("j_stable", 32'(luc_loc_o), 32'd342);
    ticks(11);
    check("j_t23_luc", 32'(luc_loc_o), 32'd408);
    tick();
    check("j_t24_luc", 32'(luc_loc_o), 32'd420);
    check("j_t24_air", 32'(airborne_o), 32'd0);
    cyc(1);

    // Hit test boundaries with the player on the ground
    player_en_i = 1'b1;
    x_i = 10'd39; y_i = 9'd420; cyc(1);
    check("rg_x39_y420", 32'(region_o), 32'd1);
    x_i = 10'd40; cyc(1);
    check("rg_x40", 32'(region_o), 32'd0);
    x_i = 10'd0; cyc(1);
    check("rg_x0", 32'(region_o), 32'd1);
    x_i = 10'd39; y_i = 9'd479; cyc(1);
    check("rg_y479", 32'(region_o), 32'd1);
    y_i = 9'd419; cyc(1);
    check("rg_y419", 32'(region_o), 32'd0);
    y_i = 9'd420; player_en_i = 1'b0; cyc(1);
    check("rg_disabled", 32'(region_o), 32'd0);

    // Ceiling clamp with JumpVel=63
    jump2_i = 1'b1; cyc(1); jump2_i = 1'b0; cyc(1);
    tick();
    check("c_t0_luc", 32'(luc2_o), 32'd420);
    check("c_t0_air", 32'(air2_o), 32'd1);
    ticks(6);
    check("c_t6_luc", 32'(luc2_o), 32'd57);
    ticks(1);
    check("c_t7_luc", 32'(luc2_o), 32'd0);
    ticks(1);
    check("c_t8_luc", 32'(luc2_o), 32'd0);
    check("c_t8_air", 32'(air2_o), 32'd1);
    ticks(1);
    check("c_t9_luc", 32'(luc2_o), 32'd1);
    ticks(1);
    check("c_t10_luc", 32'(luc2_o), 32'd3);
    check("c_main_idle", 32'(luc_loc_o), 32'd420);
    begin
      int n;
      n = 0;
      while (air2_o && n < 80) begin
        ticks(1);
        n++;
      end
      check("c_land_air", 32'(air2_o), 32'd0);
      check("c_land_luc", 32'(luc2_o), 32'd420);
    end

    // Jump held across landing does not re-trigger
    jump_i = 1'b1;
    cyc(1);
    tick();
    check("h_t0_air", 32'(airborne_o), 32'd1);
    ticks(23);
    check("h_t23_luc", 32'(luc_loc_o), 32'd408);
    tick();
    check("h_t24_luc", 32'(luc_loc_o), 32'd420);
    ticks(3);
    check("h_hold_air", 32'(airborne_o), 32'd0);
    check("h_hold_luc", 32'(luc_loc_o), 32'd420);
    jump_i = 1'b0;
    cyc(1);

    // Rising edge in the same cycle as the tick
    jump_i = 1'b1;
    frame_tick_i = 1'b1;
    cyc(1);
    frame_tick_i = 1'b0;
    jump_i = 1'b0;
    check("co_air", 32'(airborne_o), 32'd1);
    check("co_luc", 32'(luc_loc_o), 32'd420);
    cyc(1);
    tick();
    check("co_t1_luc", 32'(luc_loc_o), 32'd408);
    land("co_land");

    // Second and third press while airborne
    press();
    tick();
    ticks(11);
    tick();
    check("dj_t12_luc", 32'(luc_loc_o), 32'd342);
    press();
    tick();
    check("dj_t13_air", 32'(airborne_o), 32'd1);
`ifdef DOUBLE_JUMP_EN
    check("dj_t13_luc", 32'(luc_loc_o), 32'd342);
    cyc(1); tick();
    check("dj_t14_luc", 32'(luc_loc_o), 32'd330);
    press();
    tick();
    check("dj_t15_luc", 32'(luc_loc_o), 32'd319);
`else
    check("dj_t13_luc", 32'(luc_loc_o), 32'd343);
    cyc(1); tick();
    check("dj_t14_luc", 32'(luc_loc_o), 32'd345);
    press();
    tick();
    check("dj_t15_luc", 32'(luc_loc_o), 32'd348);
`endif
    land("dj_land");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
